// File: rtl/mem_intf_queued_pkg.sv
// mem_intf_queued_pkg: shared types for the queued memory interface
package mem_intf_queued_pkg;
   typedef enum logic {MEM_RD, MEM_WR} mem_op_t;
   typedef enum logic [1:0] {MI_IDLE, MI_REQ, MI_DONE} mi_state_t;
endpackage

// File: rtl/mem_intf_queued_req_fifo.sv
// req_fifo: synchronous request FIFO with a separate 0..DEPTH occupancy counter
module req_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp];
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/mem_intf_queued.sv
// mem_intf_queued: FIFO-buffered load/store issue to memory with a response watchdog
module mem_intf_queued
   import mem_intf_queued_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 14,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       store,
   input  logic                       load,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          result,
   output logic                       req_ready,
   output logic [$clog2(DEPTH+1)-1:0] q_count,
   output logic                       mem_done,
   output logic                       timeout_err,
   output logic [DATA_W-1:0]          datatoinst,
   output logic                       cs,
   output logic                       read_req,
   output logic                       write_req,
   output logic [ADDR_W-1:0]          addrout,
   output logic [DATA_W-1:0]          datatomem,
   input  logic [DATA_W-1:0]          datafrommem,
   input  logic                       mem_resp
);
   localparam int EW = 1 + ADDR_W + DATA_W;
   localparam int WW = $clog2(TIMEOUT+1);
   mi_state_t state, state_nxt;
   logic [WW-1:0] wdog, wdog_nxt;
   logic push, pop, full, empty;
   logic [EW-1:0] din, dout;
   mem_op_t op_in, op_hd;
   logic [ADDR_W-1:0] addr_hd, addr_nxt;
   logic [DATA_W-1:0] data_hd, dm_nxt, di_nxt;
   logic cs_nxt, rd_nxt, wr_nxt, done_nxt, err_nxt;
   assign op_in     = store ? MEM_WR : MEM_RD;
   assign push      = (store ^ load) & ~full;
   assign pop       = (state == MI_IDLE) & ~empty;
   assign req_ready = ~full;
   assign din       = {op_in, addr, result};
   assign op_hd     = mem_op_t'(dout[EW-1]);
   assign addr_hd   = dout[EW-2 -: ADDR_W];
   assign data_hd   = dout[DATA_W-1:0];
   req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(din),
      .dout(dout), .full(full), .empty(empty), .count(q_count)
   );
   always_comb begin
      state_nxt = state;
      wdog_nxt  = wdog;
      cs_nxt    = cs;
      rd_nxt    = read_req;
      wr_nxt    = write_req;
      addr_nxt  = addrout;
      dm_nxt    = datatomem;
      di_nxt    = datatoinst;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         MI_IDLE: if (!empty) begin
            state_nxt = MI_REQ;
            wdog_nxt  = '0;
            cs_nxt    = 1'b1;
            rd_nxt    = op_hd == MEM_RD;
            wr_nxt    = op_hd == MEM_WR;
            addr_nxt  = addr_hd;
            dm_nxt    = data_hd;
         end
         MI_REQ: begin
            // a response on the watchdog's final cycle still counts as success
            if (mem_resp || wdog == WW'(TIMEOUT - 1)) begin
               state_nxt = MI_DONE;
               cs_nxt    = 1'b0;
               rd_nxt    = 1'b0;
               wr_nxt    = 1'b0;
               done_nxt  = 1'b1;
               err_nxt   = ~mem_resp;
               di_nxt    = (mem_resp && read_req) ? datafrommem : datatoinst;
            end else begin
               wdog_nxt = wdog + WW'(1);
            end
         end
         MI_DONE: state_nxt = MI_IDLE;
         default: state_nxt = MI_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= MI_IDLE;
         wdog        <= '0;
         cs          <= 1'b0;
         read_req    <= 1'b0;
         write_req   <= 1'b0;
         addrout     <= '0;
         datatomem   <= '0;
         datatoinst  <= '0;
         mem_done    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         wdog        <= wdog_nxt;
         cs          <= cs_nxt;
         read_req    <= rd_nxt;
         write_req   <= wr_nxt;
         addrout     <= addr_nxt;
         datatomem   <= dm_nxt;
         datatoinst  <= di_nxt;
         mem_done    <= done_nxt;
         timeout_err <= err_nxt;
      end
   end
endmodule
